// File: rtl/trap_sequencer.sv
// Trap sequencer: arbitrates exceptions, interrupts and mret at instruction
// boundaries and runs the fixed-latency handshake with the CSR file.
module trap_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  evt_valid,
  input  logic [5:0]            exc_flags,
  input  logic [DATA_WIDTH-1:0] cur_pc,
  input  logic [DATA_WIDTH-1:0] exc_tval,
  input  logic [2:0]            irq_pending,
  input  logic [2:0]            irq_enable,
  input  logic                  mstatus_mie,
  input  logic                  mret_req,
  input  logic [DATA_WIDTH-1:0] mepc,
  output logic                  trap,
  output logic [3:0]            trap_cause,
  output logic [DATA_WIDTH-1:0] trap_value,
  output logic [DATA_WIDTH-1:0] trap_pc,
  output logic                  trap_irq,
  input  logic                  trap_handled,
  input  logic [DATA_WIDTH-1:0] trap_target_pc,
  output logic                  stall,
  output logic                  redirect_valid,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  mret_done,
  output logic                  timeout_err
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT     = 2'd2,
    REDIRECT = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [3:0]            r_cause;
  logic [DATA_WIDTH-1:0] r_value;
  logic [DATA_WIDTH-1:0] r_pc;
  logic                  r_irq;
  logic [DATA_WIDTH-1:0] r_redirect_pc;
  logic                  r_is_mret;
  logic                  r_timeout_err;

  logic                  w_idle;
  logic [2:0]            w_irq_act;
  logic                  w_exc_pend;
  logic                  w_irq_pend;
  logic                  w_mret_pend;
  logic                  w_accept;
  logic                  w_cnt_expired;

  // Exception priority: fetch misaligned > illegal > ebreak > ecall > load > store.
  function automatic logic [3:0] f_exc_cause(input logic [5:0] flags);
    if (flags[0])      return 4'd0;
    else if (flags[1]) return 4'd2;
    else if (flags[2]) return 4'd3;
    else if (flags[3]) return 4'd11;
    else if (flags[4]) return 4'd4;
    else               return 4'd6;
  endfunction

  // Interrupt priority: external > software > timer.
  function automatic logic [3:0] f_irq_cause(input logic [2:0] act);
    if (act[2])      return 4'd11;
    else if (act[0]) return 4'd3;
    else             return 4'd7;
  endfunction

  assign w_idle        = (r_state == IDLE);
  assign w_irq_act     = irq_pending & irq_enable;
  assign w_exc_pend    = evt_valid & (|exc_flags);
  assign w_irq_pend    = evt_valid & mstatus_mie & (|w_irq_act) & ~w_exc_pend;
  assign w_mret_pend   = evt_valid & mret_req & ~w_exc_pend & ~w_irq_pend;
  assign w_accept      = w_idle & (w_exc_pend | w_irq_pend | w_mret_pend);
  assign w_cnt_expired = (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_exc_pend || w_irq_pend) w_state_nxt = ISSUE;
        else if (w_mret_pend)         w_state_nxt = REDIRECT;
      end
      ISSUE:    w_state_nxt = WAIT;
      WAIT: begin
        if (trap_handled)       w_state_nxt = REDIRECT;
        else if (w_cnt_expired) w_state_nxt = IDLE;
      end
      REDIRECT: w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  // Trap record is only written on acceptance, so it stays stable for the whole sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt         <= '0;
      r_cause       <= '0;
      r_value       <= '0;
      r_pc          <= '0;
      r_irq         <= 1'b0;
      r_redirect_pc <= '0;
      r_is_mret     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_exc_pend || w_irq_pend) begin
            r_cause   <= w_exc_pend ? f_exc_cause(exc_flags) : f_irq_cause(w_irq_act);
            r_value   <= w_exc_pend ? exc_tval : '0;
            r_pc      <= cur_pc;
            r_irq     <= ~w_exc_pend;
            r_is_mret <= 1'b0;
          end else if (w_mret_pend) begin
            r_redirect_pc <= mepc;
            r_is_mret     <= 1'b1;
          end
        end
        ISSUE: r_cnt <= '0;
        WAIT: begin
          if (trap_handled) begin
            r_redirect_pc <= trap_target_pc;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_cnt_expired) r_timeout_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign trap           = (r_state == ISSUE);
  assign redirect_valid = (r_state == REDIRECT);
  assign mret_done      = (r_state == REDIRECT) & r_is_mret;
  assign stall          = ~w_idle | w_accept;
  assign trap_cause     = r_cause;
  assign trap_value     = r_value;
  assign trap_pc        = r_pc;
  assign trap_irq       = r_irq;
  assign redirect_pc    = r_redirect_pc;
  assign timeout_err    = r_timeout_err;

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: exception/interrupt/mret paths, priority,
// timeout and asynchronous reset in the middle of a sequence.
module tb_trap_sequencer;

  logic        clk;
  logic        rst_n;
  logic        evt_valid;
  logic [5:0]  exc_flags;
  logic [31:0] cur_pc;
  logic [31:0] exc_tval;
  logic [2:0]  irq_pending;
  logic [2:0]  irq_enable;
  logic        mstatus_mie;
  logic        mret_req;
  logic [31:0] mepc;
  logic        trap;
  logic [3:0]  trap_cause;
  logic [31:0] trap_value;
  logic [31:0] trap_pc;
  logic        trap_irq;
  logic        trap_handled;
  logic [31:0] trap_target_pc;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mret_done;
  logic        timeout_err;

  int n_checks;
  int n_errors;

  trap_sequencer #(.DATA_WIDTH(32), .TIMEOUT(4)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .evt_valid      (evt_valid),
    .exc_flags      (exc_flags),
    .cur_pc         (cur_pc),
    .exc_tval       (exc_tval),
    .irq_pending    (irq_pending),
    .irq_enable     (irq_enable),
    .mstatus_mie    (mstatus_mie),
    .mret_req       (mret_req),
    .mepc           (mepc),
    .trap           (trap),
    .trap_cause     (trap_cause),
    .trap_value     (trap_value),
    .trap_pc        (trap_pc),
    .trap_irq       (trap_irq),
    .trap_handled   (trap_handled),
    .trap_target_pc (trap_target_pc),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mret_done      (mret_done),
    .timeout_err    (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    evt_valid   = 1'b0;
    exc_flags   = '0;
    irq_pending = '0;
    irq_enable  = '0;
    mstatus_mie = 1'b0;
    mret_req    = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_trap"},  32'(trap),           32'd0);
    check({tag, "_irq"},   32'(trap_irq),       32'd0);
    check({tag, "_stall"}, 32'(stall),          32'd0);
    check({tag, "_rv"},    32'(redirect_valid), 32'd0);
    check({tag, "_md"},    32'(mret_done),      32'd0);
    check({tag, "_terr"},  32'(timeout_err),    32'd0);
    check({tag, "_cause"}, 32'(trap_cause),     32'd0);
    check({tag, "_value"}, trap_value,          32'd0);
    check({tag, "_pc"},    trap_pc,             32'd0);
    check({tag, "_rpc"},   redirect_pc,         32'd0);
  endtask

  // Full trap sequence from an IDLE cycle T; trap_handled is raised early in
  // ISSUE with a bogus target to show it is ignored outside WAIT.
  task automatic run_trap(input string tag, input logic [5:0] f, input logic [2:0] ip,
                          input logic [2:0] ie, input logic mie, input logic [31:0] pc,
                          input logic [31:0] tv, input logic [3:0] ecause, input logic eirq,
                          input logic [31:0] evalue, input logic [31:0] tgt);
    evt_valid = 1'b1; exc_flags = f; irq_pending = ip; irq_enable = ie;
    mstatus_mie = mie; cur_pc = pc; exc_tval = tv;
    #1;
    check({tag, "_stall_T"}, 32'(stall), 32'd1);
    tick();
    clear_inputs();
    trap_handled = 1'b1; trap_target_pc = 32'hBAD0;
    check({tag, "_trap_T1"},  32'(trap),           32'd1);
    check({tag, "_cause_T1"}, 32'(trap_cause),     32'(ecause));
    check({tag, "_irq_T1"},   32'(trap_irq),       32'(eirq));
    check({tag, "_value_T1"}, trap_value,          evalue);
    check({tag, "_pc_T1"},    trap_pc,             pc);
    check({tag, "_rv_T1"},    32'(redirect_valid), 32'd0);
    tick();
    check({tag, "_trap_T2"},  32'(trap),  32'd0);
    check({tag, "_stall_T2"}, 32'(stall), 32'd1);
    trap_handled = 1'b1; trap_target_pc = tgt;
    tick();
    trap_handled = 1'b0;
    check({tag, "_rv_T3"},    32'(redirect_valid), 32'd1);
    check({tag, "_rpc_T3"},   redirect_pc,         tgt);
    check({tag, "_md_T3"},    32'(mret_done),      32'd0);
    check({tag, "_cause_T3"}, 32'(trap_cause),     32'(ecause));
    check({tag, "_pc_T3"},    trap_pc,             pc);
    tick();
    check({tag, "_rv_T4"},    32'(redirect_valid), 32'd0);
    check({tag, "_stall_T4"}, 32'(stall),          32'd0);
  endtask

  logic [3:0] exp_causes [6];

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_causes = '{4'd0, 4'd2, 4'd3, 4'd11, 4'd4, 4'd6};
    rst_n = 1'b0;
    clear_inputs();
    cur_pc = '0; exc_tval = '0; mepc = '0;
    trap_handled = 1'b0; trap_target_pc = '0;
    repeat (3) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Illegal instruction
    run_trap("illegal", 6'b000010, 3'b000, 3'b000, 1'b0, 32'h100, 32'hDEAD,
             4'd2, 1'b0, 32'hDEAD, 32'h200);

    // Each exception bit alone
    for (int i = 0; i < 6; i++) begin
      run_trap($sformatf("exc%0d", i), 6'(1 << i), 3'b000, 3'b000, 1'b0,
               32'h1000 + 32'(i * 4), 32'hA000 + 32'(i), exp_causes[i], 1'b0,
               32'hA000 + 32'(i), 32'h2000 + 32'(i * 16));
    end

    // ebreak beats ecall and a pending MEI
    run_trap("prio", 6'b001100, 3'b100, 3'b111, 1'b1, 32'h300, 32'h55,
             4'd3, 1'b0, 32'h55, 32'h400);

    // MSI beats MTI; trap_value forced to 0
    run_trap("irq", 6'b000000, 3'b011, 3'b111, 1'b1, 32'h40, 32'h999,
             4'd3, 1'b1, 32'h0, 32'h80);
    // MEI beats MSI
    run_trap("mei", 6'b000000, 3'b101, 3'b111, 1'b1, 32'h44, 32'h0,
             4'd11, 1'b1, 32'h0, 32'h90);

    // Interrupt masked by mstatus_mie
    evt_valid = 1'b1; irq_pending = 3'b011; irq_enable = 3'b111; mstatus_mie = 1'b0;
    #1;
    check("nomie_stall_T", 32'(stall), 32'd0);
    tick();
    clear_inputs();
    check("nomie_trap", 32'(trap), 32'd0);
    check("nomie_stall", 32'(stall), 32'd0);

    // No event without evt_valid; trap_handled ignored in IDLE
    exc_flags = 6'b111111; mret_req = 1'b1; trap_handled = 1'b1;
    #1;
    check("noevt_stall_T", 32'(stall), 32'd0);
    tick();
    clear_inputs();
    trap_handled = 1'b0;
    check("noevt_trap", 32'(trap), 32'd0);
    check("noevt_rv", 32'(redirect_valid), 32'd0);

    // mret
    evt_valid = 1'b1; mret_req = 1'b1; mepc = 32'h84;
    #1;
    check("mret_stall_T", 32'(stall), 32'd1);
    tick();
    clear_inputs();
    check("mret_rv", 32'(redirect_valid), 32'd1);
    check("mret_md", 32'(mret_done), 32'd1);
    check("mret_rpc", redirect_pc, 32'h84);
    check("mret_trap", 32'(trap), 32'd0);
    tick();
    check("mret_rv_T2", 32'(redirect_valid), 32'd0);
    check("mret_md_T2", 32'(mret_done), 32'd0);
    check("mret_stall_T2", 32'(stall), 32'd0);

    // Timeout: four WAIT cycles with no acknowledge
    evt_valid = 1'b1; exc_flags = 6'b000001; cur_pc = 32'h500; exc_tval = 32'h501;
    tick();
    clear_inputs();
    check("to_trap", 32'(trap), 32'd1);
    check("to_cause", 32'(trap_cause), 32'd0);
    for (int w = 0; w < 4; w++) begin
      tick();
      check($sformatf("to_wait%0d_stall", w), 32'(stall), 32'd1);
      check($sformatf("to_wait%0d_terr", w), 32'(timeout_err), 32'd0);
      check($sformatf("to_wait%0d_rv", w), 32'(redirect_valid), 32'd0);
    end
    tick();
    check("to_terr", 32'(timeout_err), 32'd1);
    check("to_stall", 32'(stall), 32'd0);
    check("to_rv", 32'(redirect_valid), 32'd0);
    check("to_rpc", redirect_pc, 32'h84);
    tick();
    check("to_rv_late", 32'(redirect_valid), 32'd0);

    // Sticky through a normal trap
    run_trap("sticky", 6'b010000, 3'b000, 3'b000, 1'b0, 32'h600, 32'h601,
             4'd4, 1'b0, 32'h601, 32'h700);
    check("sticky_terr", 32'(timeout_err), 32'd1);

    // Reset in the middle of WAIT
    evt_valid = 1'b1; exc_flags = 6'b100000; cur_pc = 32'h800; exc_tval = 32'h801;
    tick();
    clear_inputs();
    tick();
    check("midrst_stall_pre", 32'(stall), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    tick();
    rst_n = 1'b1;
    tick();
    run_trap("post", 6'b000100, 3'b000, 3'b000, 1'b0, 32'h900, 32'h901,
             4'd3, 1'b0, 32'h901, 32'hA00);
    check("post_terr", 32'(timeout_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
